// File: rtl/ro_puf_eval_ctrl_pkg.sv
// Shared types and default sizing for the ring-oscillator PUF evaluation controller.
// Reset throughout this block is asynchronous and asserted HIGH on rst_n.
package ro_puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_COMPARE,
        ST_DONE
    } state_t;

    localparam int DEF_NUM_RO     = 32;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_SETTLE_CYC = 4;

endpackage

// File: rtl/ro_puf_eval_ctrl_if.sv
// Host-side request/result bundle of the PUF evaluation controller.
interface ro_puf_eval_ctrl_if
    import ro_puf_pkg::*;
#(
    parameter int SEL_W     = $clog2(DEF_NUM_RO),
    parameter int WIN_W     = 16,
    parameter int RESP_BITS = 8
);

    logic                 start;
    logic                 abort;
    logic [SEL_W-1:0]     seed_a;
    logic [SEL_W-1:0]     seed_b;
    logic [WIN_W-1:0]     window;
    logic                 busy;
    logic                 done;
    logic                 valid;
    logic [RESP_BITS-1:0] response;
    logic                 tie;

    modport master (
        output start, abort, seed_a, seed_b, window,
        input  busy, done, valid, response, tie
    );

    modport slave (
        input  start, abort, seed_a, seed_b, window,
        output busy, done, valid, response, tie
    );

endinterface

// File: rtl/ro_puf_eval_ctrl_edge_counter.sv
// Brings one asynchronous ring output into the clk domain and counts its rising
// edges into a saturating counter. rst_n is asynchronous, active-high.
module ro_edge_counter
    import ro_puf_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             ro,
    output logic [CNT_W-1:0] count
);

    // [0],[1] form the synchroniser, [2] holds the previous synchronised level.
    logic [2:0] sync_q;
    logic       rise;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the synchroniser chain.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], ro};
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && rise && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ro_puf_eval_ctrl.sv
// Two-bank ring-oscillator PUF measurement controller: per step, select one ring
// per bank, settle, count edges over a window, and shift in one comparison bit.
module ro_puf_eval_ctrl
    import ro_puf_pkg::*;
#(
    parameter int NUM_RO     = DEF_NUM_RO,
    parameter int SEL_W      = $clog2(NUM_RO),
    parameter int CNT_W      = DEF_CNT_W,
    parameter int WIN_W      = 16,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int RESP_BITS  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    ro_puf_eval_ctrl_if.slave   bus,
    input  logic                ro_a,
    input  logic                ro_b,
    output logic [SEL_W-1:0]    sel_a,
    output logic [SEL_W-1:0]    sel_b,
    output logic                ro_en
);

    localparam int               K_W         = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam logic [K_W-1:0]   K_LAST      = K_W'(RESP_BITS - 1);
    localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SETTLE_CYC - 1);
    localparam logic [SEL_W-1:0] SEL_MASK    = SEL_W'(NUM_RO - 1);

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     seed_a_q, seed_b_q;
    logic [WIN_W-1:0]     win_q;
    logic [WIN_W-1:0]     phase_q;
    logic [K_W-1:0]       k_q;
    logic [RESP_BITS-1:0] resp_q;
    logic                 tie_q;
    logic                 valid_q;
    logic [CNT_W-1:0]     cnt_a, cnt_b;

    logic accept;
    logic abort_run;
    logic settle_end;
    logic measure_end;
    logic step_last;

    assign accept      = (state_q == ST_IDLE) && bus.start && !bus.abort;
    assign abort_run   = (state_q != ST_IDLE) && bus.abort;
    assign settle_end  = (phase_q == SETTLE_LAST);
    assign measure_end = (phase_q == win_q - WIN_W'(1));
    assign step_last   = (k_q == K_LAST);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets its default before the case so that no path leaves it
    // unassigned; a missing default here infers a latch.
    always_comb begin
        state_d = state_q;
        if (abort_run) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:    if (accept)      state_d = ST_SETTLE;
                ST_SETTLE:  if (settle_end)  state_d = ST_MEASURE;
                ST_MEASURE: if (measure_end) state_d = ST_COMPARE;
                ST_COMPARE: state_d = step_last ? ST_DONE : ST_SETTLE;
                ST_DONE:    state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            seed_a_q <= '0;
            seed_b_q <= '0;
            win_q    <= '0;
            phase_q  <= '0;
            k_q      <= '0;
            resp_q   <= '0;
            tie_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            // phase_q times both SETTLE and MEASURE; it restarts on every state change.
            if ((state_q == ST_IDLE) || (state_d != state_q)) begin
                phase_q <= '0;
            end else begin
                phase_q <= phase_q + WIN_W'(1);
            end

            if (accept) begin
                seed_a_q <= bus.seed_a;
                seed_b_q <= bus.seed_b;
                win_q    <= (bus.window == '0) ? WIN_W'(1) : bus.window;
                k_q      <= '0;
                resp_q   <= '0;
                tie_q    <= 1'b0;
                valid_q  <= 1'b0;
            end

            if ((state_q == ST_COMPARE) && !bus.abort) begin
                resp_q[k_q] <= (cnt_a > cnt_b);
                if (cnt_a == cnt_b) begin
                    tie_q <= 1'b1;
                end
                if (step_last) begin
                    valid_q <= 1'b1;
                end else begin
                    k_q <= k_q + K_W'(1);
                end
            end

            if (abort_run) begin
                valid_q <= 1'b0;
            end
        end
    end

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q == ST_SETTLE),
        .en    (state_q == ST_MEASURE),
        .ro    (ro_a),
        .count (cnt_a)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q == ST_SETTLE),
        .en    (state_q == ST_MEASURE),
        .ro    (ro_b),
        .count (cnt_b)
    );

    // Rings run from the first SETTLE cycle through the last COMPARE cycle.
    assign ro_en = (state_q == ST_SETTLE) || (state_q == ST_MEASURE) || (state_q == ST_COMPARE);
    assign sel_a = ro_en ? ((seed_a_q + SEL_W'(k_q)) & SEL_MASK) : '0;
    assign sel_b = ro_en ? ((seed_b_q + SEL_W'(k_q)) & SEL_MASK) : '0;

    assign bus.busy     = ro_en;
    assign bus.done     = (state_q == ST_DONE);
    assign bus.valid    = valid_q;
    assign bus.response = resp_q;
    assign bus.tie      = tie_q;

endmodule

// File: tb/tb_ro_puf_eval_ctrl.sv
// Self-checking bench: behavioural ring banks behind the muxes, expected results
// queued at each start and compared when done pulses.
module tb_ro_puf_eval_ctrl;
    import ro_puf_pkg::*;

    localparam int NUM_RO     = 32;
    localparam int SEL_W      = 5;
    localparam int CNT_W      = 4;
    localparam int WIN_W      = 16;
    localparam int SETTLE_CYC = 4;
    localparam int RESP_BITS  = 8;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             ro_a = 1'b0;
    logic             ro_b = 1'b0;
    logic [SEL_W-1:0] sel_a, sel_b;
    logic             ro_en;

    always #5 clk = ~clk;

    ro_puf_eval_ctrl_if #(.SEL_W(SEL_W), .WIN_W(WIN_W), .RESP_BITS(RESP_BITS)) bus ();

    ro_puf_eval_ctrl #(
        .NUM_RO(NUM_RO), .SEL_W(SEL_W), .CNT_W(CNT_W), .WIN_W(WIN_W),
        .SETTLE_CYC(SETTLE_CYC), .RESP_BITS(RESP_BITS)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .ro_a  (ro_a),
        .ro_b  (ro_b),
        .sel_a (sel_a),
        .sel_b (sel_b),
        .ro_en (ro_en)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Ring periods in clk cycles, per mux index, for each bank.
    int per_a[NUM_RO];
    int per_b[NUM_RO];
    int ph_a = 0;
    int ph_b = 0;

    always @(negedge clk) begin
        if (!ro_en) begin
            ro_a = 1'b0; ph_a = 0;
            ro_b = 1'b0; ph_b = 0;
        end else begin
            ph_a++;
            if (ph_a >= per_a[sel_a] / 2) begin ro_a = ~ro_a; ph_a = 0; end
            ph_b++;
            if (ph_b >= per_b[sel_b] / 2) begin ro_b = ~ro_b; ph_b = 0; end
        end
    end

    typedef struct {
        logic [RESP_BITS-1:0] resp;
        logic                 tie;
        int                   lat;
        int                   sa;
        int                   sb;
    } exp_t;

    exp_t sb_q[$];

    // Nominal edge count; stimulus keeps unequal rates far enough apart that
    // the +/-1 edge alignment uncertainty cannot change the comparison.
    function automatic int est(input int per, input int w);
        int r;
        r = w / per;
        return (r > CNT_MAX) ? CNT_MAX : r;
    endfunction

    task automatic push_expect(input int sa, input int sb, input int win);
        exp_t e;
        int   w, ea, eb;
        w      = (win == 0) ? 1 : win;
        e.resp = '0;
        e.tie  = 1'b0;
        e.sa   = sa;
        e.sb   = sb;
        for (int k = 0; k < RESP_BITS; k++) begin
            ea = est(per_a[(sa + k) % NUM_RO], w);
            eb = est(per_b[(sb + k) % NUM_RO], w);
            e.resp[k] = (ea > eb);
            if (ea == eb) e.tie = 1'b1;
        end
        e.lat = 1 + RESP_BITS * (SETTLE_CYC + w + 1);
        sb_q.push_back(e);
    endtask

    // Returns #1 after the accepting edge (cycle 1 of the evaluation).
    task automatic start_eval(input int sa, input int sb, input int win, input bit expect_done);
        @(posedge clk);
        #1;
        bus.seed_a = SEL_W'(sa);
        bus.seed_b = SEL_W'(sb);
        bus.window = WIN_W'(win);
        bus.start  = 1'b1;
        if (expect_done) push_expect(sa, sb, win);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int poke_at);
        int               n;
        bit               got;
        exp_t             e;
        logic [SEL_W-1:0] log_a[$];
        logic [SEL_W-1:0] log_b[$];
        n   = 0;
        got = 1'b0;
        while (n < 3000) begin
            @(negedge clk);
            if (ro_en && ((log_a.size() == 0) || (log_a[$] != sel_a))) begin
                log_a.push_back(sel_a);
                log_b.push_back(sel_b);
            end
            if (n == 0) begin
                check({tag, " busy_after_start"}, 32'(bus.busy), 32'd1);
                check({tag, " valid_cleared"}, 32'(bus.valid), 32'd0);
            end
            bus.start = (n == poke_at);
            if (n == poke_at) begin
                bus.seed_a = bus.seed_a + SEL_W'(7);
                bus.window = WIN_W'(3);
            end
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            n++;
        end
        bus.start = 1'b0;
        check({tag, " done_seen"}, 32'(got), 32'd1);
        e = sb_q.pop_front();
        if (got) begin
            check({tag, " response"}, 32'(bus.response), 32'(e.resp));
            check({tag, " tie"}, 32'(bus.tie), 32'(e.tie));
            check({tag, " valid_at_done"}, 32'(bus.valid), 32'd1);
            check({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
            check({tag, " ro_en_at_done"}, 32'(ro_en), 32'd0);
            check({tag, " latency"}, 32'(n + 1), 32'(e.lat));
            check({tag, " step_count"}, 32'(log_a.size()), 32'(RESP_BITS));
            for (int k = 0; k < log_a.size() && k < RESP_BITS; k++) begin
                check($sformatf("%s sel_a[%0d]", tag, k), 32'(log_a[k]), 32'((e.sa + k) % NUM_RO));
                check($sformatf("%s sel_b[%0d]", tag, k), 32'(log_b[k]), 32'((e.sb + k) % NUM_RO));
            end
            @(negedge clk);
            check({tag, " done_one_cycle"}, 32'(bus.done), 32'd0);
            check({tag, " valid_holds"}, 32'(bus.valid), 32'd1);
        end
    endtask

    task automatic set_rates(input int pa, input int pb);
        for (int i = 0; i < NUM_RO; i++) begin
            per_a[i] = pa;
            per_b[i] = pb;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int done_cnt;

        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.seed_a = '0;
        bus.seed_b = '0;
        bus.window = '0;
        set_rates(4, 6);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset valid", 32'(bus.valid), 32'd0);
        check("reset response", 32'(bus.response), 32'd0);
        check("reset tie", 32'(bus.tie), 32'd0);
        check("reset ro_en", 32'(ro_en), 32'd0);
        check("reset sel_a", 32'(sel_a), 32'd0);
        check("reset sel_b", 32'(sel_b), 32'd0);
        rst_n = 1'b0;

        // Bank A faster everywhere.
        set_rates(4, 6);
        start_eval(3, 17, 64, 1'b1);
        wait_done("basic", -1);

        // Bank B faster; a start mid-run with new seed/window must be ignored.
        set_rates(8, 4);
        start_eval(0, 0, 64, 1'b1);
        wait_done("reversed", 100);

        // Bank A faster only on even steps.
        set_rates(8, 6);
        for (int i = 0; i < NUM_RO; i++) per_a[i] = (((i - 10) & 1) == 0) ? 4 : 8;
        start_eval(10, 20, 64, 1'b1);
        wait_done("pattern", -1);

        // Same indices on both banks with identical rings, selector wraps past 31.
        set_rates(6, 6);
        start_eval(30, 30, 64, 1'b1);
        wait_done("wrap_tie", -1);

        // Bank A far beyond the counter range must saturate, not wrap.
        set_rates(2, 8);
        start_eval(5, 9, 100, 1'b1);
        wait_done("saturate", -1);
        check("saturate cnt_a", 32'(u_dut.u_cnt_a.count), 32'(CNT_MAX));

        // Zero window behaves as a one-cycle window.
        set_rates(6, 6);
        start_eval(1, 1, 0, 1'b1);
        wait_done("win0", -1);

        // Abort during step 3 MEASURE (cycles 212..275).
        set_rates(4, 6);
        start_eval(0, 4, 64, 1'b0);
        check("abort valid_cleared", 32'(bus.valid), 32'd0);
        repeat (219) @(posedge clk);
        @(negedge clk);
        check("abort step3 sel_a", 32'(sel_a), 32'd3);
        check("abort busy_before", 32'(bus.busy), 32'd1);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort ro_en", 32'(ro_en), 32'd0);
        check("abort valid", 32'(bus.valid), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        check("abort partial_response", 32'(bus.response), 32'h07);
        done_cnt = 0;
        repeat (400) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("abort no_done", 32'(done_cnt), 32'd0);

        // Abort and start together in IDLE: abort wins.
        @(posedge clk);
        #1;
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check("abort_start busy", 32'(bus.busy), 32'd0);
        check("abort_start ro_en", 32'(ro_en), 32'd0);

        // Asynchronous reset in step 2 MEASURE (cycles 143..206).
        set_rates(4, 6);
        start_eval(0, 4, 64, 1'b0);
        repeat (148) @(posedge clk);
        #3;
        check("areset partial_before", 32'(bus.response), 32'h03);
        rst_n = 1'b1;
        #1;
        check("areset busy", 32'(bus.busy), 32'd0);
        check("areset ro_en", 32'(ro_en), 32'd0);
        check("areset sel_a", 32'(sel_a), 32'd0);
        check("areset sel_b", 32'(sel_b), 32'd0);
        check("areset response", 32'(bus.response), 32'd0);
        check("areset valid", 32'(bus.valid), 32'd0);
        check("areset tie", 32'(bus.tie), 32'd0);
        check("areset cnt_a", 32'(u_dut.u_cnt_a.count), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
